// File: rtl/bank_search_controller.sv
// Bank search controller: steps a bits detector through its frequency banks,
// hunting for a preamble on each. Once the preamble is found it forwards the
// payload bits and reports done, or reports fail on lost lock or exhausted banks.
module bank_search_controller #(
   parameter int                   BANKS     = 4,
   parameter int                   PRE_LEN   = 6,
   parameter logic [PRE_LEN-1:0]   PREAMBLE  = 6'b101011,
   parameter int                   TIMEOUT   = 4096,
   parameter int                   FLUSH_CYC = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [7:0]                 n_bits,
   input  logic                       det_dat,
   input  logic                       det_vld,
   output logic                       det_rst,
   output logic [$clog2(BANKS)-1:0]   bank,
   output logic                       bit_dat,
   output logic                       bit_vld,
   output logic                       busy,
   output logic                       locked,
   output logic                       done,
   output logic                       fail
);

   localparam int BW = $clog2(BANKS);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int FW = $clog2(FLUSH_CYC + 1);
   localparam int RW = $clog2(PRE_LEN);

   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
   localparam logic [FW-1:0] F_LAST = FW'(FLUSH_CYC - 1);
   localparam logic [RW-1:0] R_FULL = RW'(PRE_LEN - 1);
   localparam logic [BW-1:0] B_LAST = BW'(BANKS - 1);

   typedef enum logic [2:0] {
      IDLE, FLUSH, HUNT, PAYLOAD, DONE, FAIL
   } state_t;

   state_t               state_q, state_d;
   logic [BW-1:0]        bank_q, bank_d;
   logic [7:0]           nb_q, nb_d;
   logic [FW-1:0]        fcnt_q, fcnt_d;
   logic [TW-1:0]        tmr_q, tmr_d;
   logic [RW-1:0]        rcnt_q, rcnt_d;
   logic [7:0]           pcnt_q, pcnt_d;
   logic [PRE_LEN-1:0]   shreg_q, shreg_d;
   logic                 det_rst_q, det_rst_d;
   logic                 bit_dat_q, bit_dat_d;
   logic                 bit_vld_q, bit_vld_d;
   logic                 busy_q, busy_d;
   logic                 locked_q, locked_d;
   logic                 done_q, done_d;
   logic                 fail_q, fail_d;
   logic [PRE_LEN-1:0]   window;
   logic                 match;
   logic [7:0]           pcnt_inc;

   // Next-state and next-output logic; outputs are derived from the next state
   // so every output register lines up with the state register.
   always_comb begin
      state_d   = state_q;
      bank_d    = bank_q;
      nb_d      = nb_q;
      fcnt_d    = fcnt_q;
      tmr_d     = tmr_q;
      rcnt_d    = rcnt_q;
      pcnt_d    = pcnt_q;
      shreg_d   = shreg_q;
      bit_dat_d = bit_dat_q;
      bit_vld_d = 1'b0;
      window    = {shreg_q[PRE_LEN-2:0], det_dat};
      // A match needs PRE_LEN-1 earlier bits so cleared shreg zeros never count.
      match     = det_vld && (window == PREAMBLE) && (rcnt_q == R_FULL);
      pcnt_inc  = pcnt_q + 8'd1;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = FLUSH;
               bank_d  = '0;
               nb_d    = n_bits;
               fcnt_d  = '0;
            end
         end
         FLUSH: begin
            // Clear the hunt context here so HUNT always starts clean.
            fcnt_d  = fcnt_q + 1'b1;
            tmr_d   = '0;
            rcnt_d  = '0;
            shreg_d = '0;
            if (fcnt_q == F_LAST)
               state_d = HUNT;
         end
         HUNT: begin
            tmr_d = tmr_q + 1'b1;
            if (det_vld) begin
               shreg_d = window;
               if (rcnt_q != R_FULL)
                  rcnt_d = rcnt_q + 1'b1;
            end
            if (match) begin
               tmr_d   = '0;
               pcnt_d  = '0;
               state_d = (nb_q == 8'd0) ? DONE : PAYLOAD;
            end else if (tmr_q == T_LAST) begin
               if (bank_q == B_LAST) begin
                  state_d = FAIL;
               end else begin
                  bank_d  = bank_q + 1'b1;
                  fcnt_d  = '0;
                  state_d = FLUSH;
               end
            end
         end
         PAYLOAD: begin
            tmr_d = tmr_q + 1'b1;
            if (det_vld) begin
               tmr_d     = '0;
               bit_vld_d = 1'b1;
               bit_dat_d = det_dat;
               pcnt_d    = pcnt_inc;
               if (pcnt_inc == nb_q)
                  state_d = DONE;
            end else if (tmr_q == T_LAST) begin
               state_d = FAIL;
            end
         end
         DONE:    state_d = IDLE;
         FAIL:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d    = (state_d != IDLE);
      locked_d  = (state_d == PAYLOAD);
      done_d    = (state_d == DONE);
      fail_d    = (state_d == FAIL);
      det_rst_d = !((state_d == HUNT) || (state_d == PAYLOAD));
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         bank_q    <= '0;
         nb_q      <= '0;
         fcnt_q    <= '0;
         tmr_q     <= '0;
         rcnt_q    <= '0;
         pcnt_q    <= '0;
         shreg_q   <= '0;
         det_rst_q <= 1'b1;
         bit_dat_q <= 1'b0;
         bit_vld_q <= 1'b0;
         busy_q    <= 1'b0;
         locked_q  <= 1'b0;
         done_q    <= 1'b0;
         fail_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bank_q    <= bank_d;
         nb_q      <= nb_d;
         fcnt_q    <= fcnt_d;
         tmr_q     <= tmr_d;
         rcnt_q    <= rcnt_d;
         pcnt_q    <= pcnt_d;
         shreg_q   <= shreg_d;
         det_rst_q <= det_rst_d;
         bit_dat_q <= bit_dat_d;
         bit_vld_q <= bit_vld_d;
         busy_q    <= busy_d;
         locked_q  <= locked_d;
         done_q    <= done_d;
         fail_q    <= fail_d;
      end
   end

   assign det_rst = det_rst_q;
   assign bank    = bank_q;
   assign bit_dat = bit_dat_q;
   assign bit_vld = bit_vld_q;
   assign busy    = busy_q;
   assign locked  = locked_q;
   assign done    = done_q;
   assign fail    = fail_q;

endmodule

// File: doc/bank_search_controller.md
BANK_SEARCH_CONTROLLER -- requirements
Module: bank_search_controller

Interface
REQ-001 Parameter BANKS, default 4, number of detector frequency banks (legal range 2..16).
REQ-002 Parameter PRE_LEN, default 6, preamble length in bits.
REQ-003 Parameter PREAMBLE, default 6'b101011, expected preamble, MSB received first.
REQ-004 Parameter TIMEOUT, default 4096, clk cycles allowed per hunt/bit-gap before giving up.
REQ-005 Parameter FLUSH_CYC, default 2, cycles det_rst is held on each bank change.
REQ-006 clk  input  1  clock.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 start  input  1  one-cycle pulse; begins a frame search.
REQ-009 n_bits  input  8  payload bit count; sampled on an accepted start.
REQ-010 det_dat  input  1  decoded bit from the bits detector.
REQ-011 det_vld  input  1  det_dat valid strobe.
REQ-012 det_rst  output  1  synchronous reset driven to the bits detector.
REQ-013 bank  output  $clog2(BANKS)  frequency_bank select to the bits detector.
REQ-014 bit_dat / bit_vld  output  1 / 1  payload bit and its strobe.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 locked  output  1  high in PAYLOAD.
REQ-017 done / fail  output  1 / 1  one-cycle completion / failure pulses.

Function
REQ-018 States SHALL be IDLE, FLUSH, HUNT, PAYLOAD, DONE and FAIL; all outputs SHALL be registered.
REQ-019 IDLE: start=1 -> FLUSH, bank<=0, n_bits latched; start in any other state SHALL be ignored.
REQ-020 FLUSH: det_rst=1 for exactly FLUSH_CYC cycles with bank stable, then HUNT; det_rst SHALL also be 1 in IDLE, DONE and FAIL, and 0 in HUNT and PAYLOAD.
REQ-021 HUNT: on entry, the PRE_LEN-bit shift register, received-bit counter and timer SHALL clear; each det_vld shifts det_dat in at the LSB.
REQ-022 Match SHALL be det_vld=1 and {shreg[PRE_LEN-2:0],det_dat}==PREAMBLE with at least PRE_LEN-1 bits already received in this HUNT; match -> PAYLOAD, or -> DONE if latched n_bits==0.
REQ-023 HUNT timer counts clk cycles; timer==TIMEOUT-1 without a match -> FLUSH with bank+1, or -> FAIL if bank==BANKS-1; match and timeout in the same cycle -> match wins.
REQ-024 PAYLOAD: each det_vld SHALL produce bit_vld=1, bit_dat=det_dat one cycle later (latency 1) and increment the payload counter; the det_vld carrying bit n_bits -> DONE.
REQ-025 PAYLOAD: the gap timer clears on every det_vld; TIMEOUT cycles without det_vld -> FAIL (lost lock), no partial done.
REQ-026 Preamble bits SHALL never appear on bit_vld.
REQ-027 DONE pulses done=1 for one cycle and FAIL pulses fail=1 for one cycle, then -> IDLE; bank SHALL hold its last value until the next start.
REQ-028 All counters SHALL saturate-free wrap only by explicit state transitions; timer width $clog2(TIMEOUT+1), payload counter 8 bits.

Reset
REQ-029 rst=1 SHALL force IDLE, bank=0, det_rst=1, bit_dat=bit_vld=busy=locked=done=fail=0, and clear all counters and the shift register, including when asserted mid-HUNT or mid-PAYLOAD.
REQ-030 The first start SHALL be accepted on the first cycle after rst deasserts.

Verification
REQ-031 start, n_bits=4; bank 0 delivers 101011 then 1,0,0,1 -> det_rst high for 2 cycles, locked, bit_vld x4 with data 1,0,0,1, done pulse, bank=0.
REQ-032 TIMEOUT=64; no det_vld on banks 0,1; bank 2 delivers preamble -> bank steps 0->1->2 with 2-cycle det_rst each step, locked on bank 2.
REQ-033 No preamble on any of the 4 banks -> fail pulse 4*(64+2) cycles after start, bank=3, no bit_vld ever.
REQ-034 Bits 1,1,0,1,0,1,1 in HUNT -> match on the 7th bit only; the leading 1 is not forwarded; n_bits=0 -> done without bit_vld.
REQ-035 Payload stall of TIMEOUT cycles after 2 of 4 bits -> fail pulse, locked drops, no done.
REQ-036 rst asserted mid-PAYLOAD, plus start while busy -> IDLE with all outputs at reset values; the busy-time start has no effect.
